// File: rtl/instr_mem_loader_if.sv
// Load-stream and fetch bus for instr_mem_loader.
// The master side feeds bytes and issues fetch addresses; the slave is the loader.
interface instr_mem_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] address;
  logic [31:0] instruction;

  modport master (
    output start, byte_in, byte_valid, byte_last, address,
    input  byte_ready, instruction
  );

  modport slave (
    input  start, byte_in, byte_valid, byte_last, address,
    output byte_ready, instruction
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Byte-stream loader into a little-endian instruction store with a combinational word fetch port.
// Optional running checksum of accepted bytes is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int MEM_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_mem_loader_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [8:0]           words_loaded,
  output logic [7:0]           checksum
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   word_q, word_d;
  logic [8:0]    words_q, words_d;
  logic          error_q, error_d;

  logic [7:0]    mem [MEM_BYTES];

  logic          session_start;
  logic          accept;
  logic          mem_full;
  logic          mem_we;
  logic [31:0]   wr_data;
  logic [AW-1:0] wa0, wa1, wa2, wa3;
  logic [AW-1:0] fa0, fa1, fa2, fa3;
  logic          unused_addr_hi;

  assign session_start = bus.start && (state_q != LOAD);
  assign accept        = (state_q == LOAD) && bus.byte_valid;
  assign mem_full      = (ptr_q == PW'(MEM_BYTES));

  // Merge the incoming byte into the lanes gathered so far; lanes above it stay zero.
  always_comb begin
    wr_data = 32'h0;
    unique case (lane_q)
      2'd0: wr_data = {24'h0, bus.byte_in};
      2'd1: wr_data = {16'h0, bus.byte_in, word_q[7:0]};
      2'd2: wr_data = {8'h0, bus.byte_in, word_q[15:0]};
      2'd3: wr_data = {bus.byte_in, word_q[23:0]};
      default: wr_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    word_d  = word_q;
    words_d = words_q;
    error_d = error_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = LOAD;
          ptr_d   = '0;
          lane_d  = '0;
          words_d = '0;
          error_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (mem_full) begin
            error_d = 1'b1;
          end else if (lane_q == 2'd3 || bus.byte_last) begin
            mem_we  = 1'b1;
            ptr_d   = ptr_q + PW'(4);
            words_d = words_q + 9'd1;
            lane_d  = '0;
          end else begin
            lane_d  = lane_q + 2'd1;
            word_d  = wr_data[23:0];
          end
          if (bus.byte_last) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      words_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      words_q <= words_d;
      error_q <= error_d;
    end
  end

  assign wa0 = ptr_q[AW-1:0];
  assign wa1 = wa0 + AW'(1);
  assign wa2 = wa0 + AW'(2);
  assign wa3 = wa0 + AW'(3);

  // The store itself is never reset so words survive a reset mid-session.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wa0] <= wr_data[7:0];
      mem[wa1] <= wr_data[15:8];
      mem[wa2] <= wr_data[23:16];
      mem[wa3] <= wr_data[31:24];
    end
  end

  assign fa0 = bus.address[AW-1:0];
  assign fa1 = fa0 + AW'(1);
  assign fa2 = fa0 + AW'(2);
  assign fa3 = fa0 + AW'(3);
  assign bus.instruction = {mem[fa3], mem[fa2], mem[fa1], mem[fa0]};
  assign unused_addr_hi  = ^bus.address[31:AW];

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (session_start)  csum_d = 8'h00;
    else if (accept)    csum_d = csum_q + bus.byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= 8'h00;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 8'h00;
`endif

  assign bus.byte_ready = (state_q == LOAD);
  assign busy           = (state_q == LOAD);
  assign done           = (state_q == DONE);
  assign error          = error_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a default-size instance plus a 16-byte instance
// for overflow and address-wrap cases.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_mem_loader_if big_if ();
  instr_mem_loader_if small_if ();

  logic       big_busy, big_done, big_error;
  logic [8:0] big_words;
  logic [7:0] big_csum;
  logic       small_busy, small_done, small_error;
  logic [8:0] small_words;
  logic [7:0] small_csum;

  int check_count = 0;
  int pass_count  = 0;

  logic [31:0] fetched;

  instr_mem_loader dut_big (
    .clk          (clk),
    .rst          (rst),
    .bus          (big_if),
    .busy         (big_busy),
    .done         (big_done),
    .error        (big_error),
    .words_loaded (big_words),
    .checksum     (big_csum)
  );

  instr_mem_loader #(.MEM_BYTES(16)) dut_small (
    .clk          (clk),
    .rst          (rst),
    .bus          (small_if),
    .busy         (small_busy),
    .done         (small_done),
    .error        (small_error),
    .words_loaded (small_words),
    .checksum     (small_csum)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    else
      pass_count++;
  endtask

  // Drive one cycle of stimulus on the selected instance, then release the inputs.
  task automatic applyStimulus(input bit sel, input logic st, input logic [7:0] b,
                               input logic v, input logic l);
    if (sel) begin
      small_if.start = st; small_if.byte_in = b; small_if.byte_valid = v; small_if.byte_last = l;
    end else begin
      big_if.start = st; big_if.byte_in = b; big_if.byte_valid = v; big_if.byte_last = l;
    end
    @(posedge clk);
    #1;
    big_if.start = 1'b0;   big_if.byte_valid = 1'b0;   big_if.byte_last = 1'b0;
    small_if.start = 1'b0; small_if.byte_valid = 1'b0; small_if.byte_last = 1'b0;
  endtask

  task automatic startLoad(input bit sel);
    applyStimulus(sel, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic sendByte(input bit sel, input logic [7:0] b, input logic l);
    applyStimulus(sel, 1'b0, b, 1'b1, l);
  endtask

  task automatic fetchWord(input bit sel, input logic [31:0] a, output logic [31:0] d);
    if (sel) small_if.address = a;
    else     big_if.address = a;
    #1;
    d = sel ? small_if.instruction : big_if.instruction;
  endtask

  initial begin
    big_if.start = 1'b0;   big_if.byte_in = 8'h00;   big_if.byte_valid = 1'b0;
    big_if.byte_last = 1'b0; big_if.address = 32'h0;
    small_if.start = 1'b0; small_if.byte_in = 8'h00; small_if.byte_valid = 1'b0;
    small_if.byte_last = 1'b0; small_if.address = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(big_busy), 32'h0);
    checkOutput("rst_done", 32'(big_done), 32'h0);
    checkOutput("rst_error", 32'(big_error), 32'h0);
    checkOutput("rst_words", 32'(big_words), 32'h0);
    checkOutput("rst_csum", 32'(big_csum), 32'h0);
    checkOutput("rst_ready", 32'(big_if.byte_ready), 32'h0);
    rst = 1'b0;

    // Single aligned word
    startLoad(0);
    checkOutput("load_busy", 32'(big_busy), 32'h1);
    checkOutput("load_ready", 32'(big_if.byte_ready), 32'h1);
    sendByte(0, 8'h78, 1'b0);
    sendByte(0, 8'h56, 1'b0);
    sendByte(0, 8'h34, 1'b0);
    sendByte(0, 8'h12, 1'b1);
    fetchWord(0, 32'h0, fetched);
    checkOutput("w1_data", fetched, 32'h12345678);
    checkOutput("w1_words", 32'(big_words), 32'h1);
    checkOutput("w1_done", 32'(big_done), 32'h1);
    checkOutput("w1_busy", 32'(big_busy), 32'h0);
    checkOutput("w1_ready", 32'(big_if.byte_ready), 32'h0);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("w1_csum", 32'(big_csum), 32'h14);
`else
    checkOutput("w1_csum", 32'(big_csum), 32'h00);
`endif

    // Restart from DONE; checksum wraps mod 256
    startLoad(0);
    checkOutput("restart_busy", 32'(big_busy), 32'h1);
    checkOutput("restart_words", 32'(big_words), 32'h0);
    sendByte(0, 8'hFF, 1'b0);
    sendByte(0, 8'h02, 1'b0);
    sendByte(0, 8'h10, 1'b0);
    sendByte(0, 8'h20, 1'b1);
    fetchWord(0, 32'h0, fetched);
    checkOutput("cs_data", fetched, 32'h201002FF);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("cs_csum", 32'(big_csum), 32'h31);
`else
    checkOutput("cs_csum", 32'(big_csum), 32'h00);
`endif

    // Six bytes: one full word plus a zero-padded partial word
    startLoad(0);
    for (int i = 1; i <= 6; i++) sendByte(0, 8'(i), i == 6);
    fetchWord(0, 32'h0, fetched);
    checkOutput("p6_word0", fetched, 32'h04030201);
    fetchWord(0, 32'h4, fetched);
    checkOutput("p6_word1", fetched, 32'h00000605);
    checkOutput("p6_words", 32'(big_words), 32'h2);
    checkOutput("p6_done", 32'(big_done), 32'h1);

    // start while loading must not disturb the session
    startLoad(0);
    sendByte(0, 8'hAA, 1'b0);
    sendByte(0, 8'hBB, 1'b0);
    applyStimulus(0, 1'b1, 8'hCC, 1'b1, 1'b0);
    sendByte(0, 8'hDD, 1'b1);
    fetchWord(0, 32'h0, fetched);
    checkOutput("ign_start_data", fetched, 32'hDDCCBBAA);
    checkOutput("ign_start_words", 32'(big_words), 32'h1);

    // Reset in the middle of the second word; also collides with start and a last byte
    startLoad(0);
    sendByte(0, 8'h11, 1'b0);
    sendByte(0, 8'h22, 1'b0);
    sendByte(0, 8'h33, 1'b0);
    sendByte(0, 8'h44, 1'b0);
    sendByte(0, 8'h55, 1'b0);
    sendByte(0, 8'h66, 1'b0);
    rst = 1'b1;
    applyStimulus(0, 1'b1, 8'h77, 1'b1, 1'b1);
    rst = 1'b0;
    checkOutput("mid_rst_busy", 32'(big_busy), 32'h0);
    checkOutput("mid_rst_done", 32'(big_done), 32'h0);
    checkOutput("mid_rst_words", 32'(big_words), 32'h0);
    checkOutput("mid_rst_error", 32'(big_error), 32'h0);
    checkOutput("mid_rst_csum", 32'(big_csum), 32'h0);
    checkOutput("mid_rst_ready", 32'(big_if.byte_ready), 32'h0);
    fetchWord(0, 32'h0, fetched);
    checkOutput("mid_rst_word0", fetched, 32'h44332211);
    fetchWord(0, 32'h4, fetched);
    checkOutput("mid_rst_word1", fetched, 32'h00000605);
    startLoad(0);
    sendByte(0, 8'h9A, 1'b0);
    sendByte(0, 8'hBC, 1'b0);
    sendByte(0, 8'hDE, 1'b0);
    sendByte(0, 8'hF0, 1'b1);
    fetchWord(0, 32'h0, fetched);
    checkOutput("reload_data", fetched, 32'hF0DEBC9A);
    checkOutput("reload_words", 32'(big_words), 32'h1);

    // Overflow on the 16-byte instance: 20 bytes, last four dropped
    startLoad(1);
    for (int i = 0; i < 20; i++) begin
      sendByte(1, 8'(i + 1), i == 19);
      if (i == 15) begin
        checkOutput("ovf_words_full", 32'(small_words), 32'h4);
        checkOutput("ovf_err_before", 32'(small_error), 32'h0);
      end
      if (i == 16) begin
        checkOutput("ovf_err_set", 32'(small_error), 32'h1);
        checkOutput("ovf_ready_held", 32'(small_if.byte_ready), 32'h1);
        checkOutput("ovf_busy_held", 32'(small_busy), 32'h1);
      end
    end
    checkOutput("ovf_done", 32'(small_done), 32'h1);
    checkOutput("ovf_error", 32'(small_error), 32'h1);
    checkOutput("ovf_words", 32'(small_words), 32'h4);
    checkOutput("ovf_ready_end", 32'(small_if.byte_ready), 32'h0);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("ovf_csum", 32'(small_csum), 32'hD2);
`else
    checkOutput("ovf_csum", 32'(small_csum), 32'h00);
`endif
    fetchWord(1, 32'd12, fetched);
    checkOutput("ovf_last_word", fetched, 32'h100F0E0D);

    // Fetch wrap-around and address aliasing
    fetchWord(1, 32'd14, fetched);
    checkOutput("wrap_14", fetched, 32'h0201100F);
    fetchWord(1, 32'd30, fetched);
    checkOutput("wrap_alias_30", fetched, 32'h0201100F);
    fetchWord(1, 32'h1000_0002, fetched);
    checkOutput("unaligned_2", fetched, 32'h06050403);

    // Restart after overflow clears the error and counters
    startLoad(1);
    checkOutput("ovf_restart_error", 32'(small_error), 32'h0);
    checkOutput("ovf_restart_words", 32'(small_words), 32'h0);
    sendByte(1, 8'hAB, 1'b1);
    fetchWord(1, 32'h0, fetched);
    checkOutput("single_byte_word", fetched, 32'h000000AB);
    checkOutput("single_byte_words", 32'(small_words), 32'h1);
    checkOutput("single_byte_done", 32'(small_done), 32'h1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
